btn_cmd_arbiter: RTL

//  Consumes the four debounced button levels (HS, VS, DF_UART, DF_VGA) and turns

---
 rtl/btn_cmd_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: turns debounced button presses into pattern-select updates
// and UART/VGA req/ack commands, serialised by a 4-way round-robin arbiter.
module btn_cmd_arbiter #(
  parameter int unsigned HS_MAX      = 7,
  parameter int unsigned VS_MAX      = 7,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       HS,
  input  logic       VS,
  input  logic       DF_UART,
  input  logic       DF_VGA,
  output logic [2:0] hs_sel,
  output logic [2:0] vs_sel,
  output logic       uart_req,
  output logic [7:0] uart_data,
  input  logic       uart_ack,
  output logic       vga_req,
  input  logic       vga_ack,
  output logic       busy,
  output logic       err_timeout
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned DAT_W = 8;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [SEL_W-1:0] HS_LAST  = SEL_W'(HS_MAX);
  localparam logic [SEL_W-1:0] VS_LAST  = SEL_W'(VS_MAX);

  localparam logic [PTR_W-1:0] SRC_HS   = 2'd0;
  localparam logic [PTR_W-1:0] SRC_VS   = 2'd1;
  localparam logic [PTR_W-1:0] SRC_UART = 2'd2;
  localparam logic [PTR_W-1:0] SRC_VGA  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_UART = 2'd1,
    S_WAIT_VGA  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [N_SRC-1:0]   r_prev;
  logic [N_SRC-1:0]   r_pend;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]   r_hs_sel, w_hs_nxt;
  logic [SEL_W-1:0]   r_vs_sel, w_vs_nxt;
  logic [DAT_W-1:0]   r_uart_data, w_udata_nxt;
  logic               r_uart_req, w_ureq_nxt;
  logic               r_vga_req, w_vreq_nxt;
  logic               r_err, w_err_nxt;

  logic [N_SRC-1:0]   w_in;
  logic [N_SRC-1:0]   w_press;
  logic [N_SRC-1:0]   w_pend_nxt;
  logic               w_gnt_valid;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [N_SRC-1:0]   w_gnt_oh;

  assign w_in    = {DF_VGA, DF_UART, VS, HS};
  assign w_press = w_in & ~r_prev;

  // Round-robin search from rr_ptr+1, only while idle
  always_comb begin
    logic [PTR_W-1:0] w_cand;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = r_rr_ptr;
    w_cand      = r_rr_ptr;
    if (r_state == S_IDLE) begin
      for (int k = 1; k < 5; k++) begin
        w_cand = r_rr_ptr + PTR_W'(k);
        if (!w_gnt_valid && r_pend[w_cand]) begin
          w_gnt_valid = 1'b1;
          w_gnt_idx   = w_cand;
        end
      end
    end
    w_gnt_oh = w_gnt_valid ? (N_SRC'(1) << w_gnt_idx) : '0;
  end

  // Pending latch: a new press beats a grant clear in the same cycle
  assign w_pend_nxt = (r_pend & ~w_gnt_oh) | w_press;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    w_hs_nxt    = r_hs_sel;
    w_vs_nxt    = r_vs_sel;
    w_udata_nxt = r_uart_data;
    w_ureq_nxt  = r_uart_req;
    w_vreq_nxt  = r_vga_req;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          w_rr_nxt = w_gnt_idx;
          unique case (w_gnt_idx)
            SRC_HS: w_hs_nxt = (r_hs_sel == HS_LAST) ? '0 : r_hs_sel + SEL_W'(1);
            SRC_VS: w_vs_nxt = (r_vs_sel == VS_LAST) ? '0 : r_vs_sel + SEL_W'(1);
            SRC_UART: begin
              w_udata_nxt = {r_hs_sel, r_vs_sel, 2'b10};
              w_ureq_nxt  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_WAIT_UART;
            end
            SRC_VGA: begin
              w_vreq_nxt  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_WAIT_VGA;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_UART: begin
        if (uart_ack) begin
          w_ureq_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_ureq_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_VGA: begin
        if (vga_ack) begin
          w_vreq_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_vreq_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ureq_nxt  = 1'b0;
        w_vreq_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, edge-detect history, pending bits and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prev      <= '1;
      r_pend      <= '0;
      r_rr_ptr    <= SRC_VGA;
      r_cnt       <= '0;
      r_hs_sel    <= '0;
      r_vs_sel    <= '0;
      r_uart_data <= '0;
      r_uart_req  <= 1'b0;
      r_vga_req   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_in;
      r_pend      <= w_pend_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hs_sel    <= w_hs_nxt;
      r_vs_sel    <= w_vs_nxt;
      r_uart_data <= w_udata_nxt;
      r_uart_req  <= w_ureq_nxt;
      r_vga_req   <= w_vreq_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign hs_sel      = r_hs_sel;
  assign vs_sel      = r_vs_sel;
  assign uart_req    = r_uart_req;
  assign uart_data   = r_uart_data;
  assign vga_req     = r_vga_req;
  assign err_timeout = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
